// File: rtl/pipelined_barrel_shifter_pkg.sv
// Shared ALU shifter package.
// Holds the datapath width, the shift-amount width and the shift opcode
// encodings used by the pipelined barrel shifter and its stages.
package pipelined_barrel_shifter_pkg;

  localparam int WIDTH      = 32;
  localparam int SHAMT_W    = 5;       // log2(WIDTH); change only together with WIDTH
  localparam int NUM_STAGES = SHAMT_W; // one stage per shift-amount bit

  localparam logic SHIFT_OP_SLL = 1'b0; // logical left, zero fill
  localparam logic SHIFT_OP_SRA = 1'b1; // arithmetic right, sign fill

  // Shift distance handled by stage k: 16, 8, 4, 2, 1.
  function automatic int stage_dist(input int k);
    return 1 << (SHAMT_W - 1 - k);
  endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_if.sv
// Operation/result bus of the pipelined barrel shifter.
// Input side : in_valid, in_ready, data_in, shamt, op
// Output side: out_valid, out_ready, data_out
// slave modport is the shifter, master modport is the client driving it.
interface pipelined_barrel_shifter_if;
  import pipelined_barrel_shifter_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   data_in;
  logic [SHAMT_W-1:0] shamt;
  logic               op;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   data_out;

  modport slave (
    input  in_valid, data_in, shamt, op, out_ready,
    output in_ready, out_valid, data_out
  );

  modport master (
    output in_valid, data_in, shamt, op, out_ready,
    input  in_ready, out_valid, data_out
  );

endinterface

// File: rtl/pipelined_barrel_shifter_shift_stage.sv
// One registered stage of the logarithmic shifter.
// Conditionally shifts the incoming word by DIST (left zero-fill or
// arithmetic right) when the shift-amount bit for this distance is set,
// then registers data, the still-unused shamt bits, op and valid.
// Ports:
//   clock, ctrl_reset_n      : clock and synchronous active-low reset
//   in_valid/in_data/in_shamt/in_op : contents offered by the previous stage
//   ready                    : this stage can take new contents this cycle
//   ready_next               : the following stage can take our contents
//   out_valid/out_data/out_shamt/out_op : registered stage contents
module shift_stage
  import pipelined_barrel_shifter_pkg::*;
#(
  parameter int DIST = 1
) (
  input  logic               clock,
  input  logic               ctrl_reset_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic               in_op,
  output logic               ready,
  input  logic               ready_next,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SHAMT_W-1:0] out_shamt,
  output logic               out_op
);

  localparam int BIT = $clog2(DIST);
  // Keeps only the shamt bits that later (smaller) stages still need.
  localparam logic [SHAMT_W-1:0] REM_MASK = (SHAMT_W'(1) << BIT) - SHAMT_W'(1);

  logic [WIDTH-1:0]   sll_data;
  logic [WIDTH-1:0]   sra_data;
  logic [WIDTH-1:0]   shifted;
  logic               valid_reg;
  logic [WIDTH-1:0]   data_reg;
  logic [SHAMT_W-1:0] shamt_reg;
  logic               op_reg;

  generate
    if (DIST == 16) begin : g_sll16
      // Existing fixed sixteen-bit left-shift wiring.
      assign sll_data = {in_data[15:0], 16'h0000};
    end else begin : g_sll
      assign sll_data = in_data << DIST;
    end
  endgenerate

  // Bit 31 never changes through the stages, so the local MSB is the
  // original operand's sign.
  assign sra_data = {{DIST{in_data[WIDTH-1]}}, in_data[WIDTH-1:DIST]};

  always_comb begin
    shifted = in_data;
    if (in_shamt[BIT]) begin
      shifted = (in_op == SHIFT_OP_SRA) ? sra_data : sll_data;
    end
  end

  // An empty stage always accepts, so bubbles collapse under a stall.
  assign ready = !valid_reg || ready_next;

  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      shamt_reg <= '0;
      op_reg    <= SHIFT_OP_SLL;
    end else if (ready) begin
      valid_reg <= in_valid;
      if (in_valid) begin
        data_reg  <= shifted;
        shamt_reg <= in_shamt & REM_MASK;
        op_reg    <= in_op;
      end
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = data_reg;
  assign out_shamt = shamt_reg;
  assign out_op    = op_reg;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Five-stage pipelined logarithmic barrel shifter (SLL / SRA, 32 bit).
// Stages shift by 16, 8, 4, 2, 1; each stage is registered, giving a
// fixed latency of five edges with full throughput and lossless
// backpressure (up to five operations buffered).
// Ports:
//   clock        : single clock, posedge
//   ctrl_reset_n : synchronous active-low reset, discards in-flight work
//   bus          : slave side of pipelined_barrel_shifter_if
//                  (in_valid/in_ready/data_in/shamt/op,
//                   out_valid/out_ready/data_out)
module pipelined_barrel_shifter
  import pipelined_barrel_shifter_pkg::*;
(
  input  logic                        clock,
  input  logic                        ctrl_reset_n,
  pipelined_barrel_shifter_if.slave   bus
);

  // Index 0 is the upstream bus, index k+1 is the output of stage k.
  logic               v   [0:NUM_STAGES];
  logic [WIDTH-1:0]   d   [0:NUM_STAGES];
  logic [SHAMT_W-1:0] s   [0:NUM_STAGES];
  logic               o   [0:NUM_STAGES];
  // rdy[k] is the ready of stage k; rdy[NUM_STAGES] is downstream.
  logic               rdy [0:NUM_STAGES];

  assign v[0] = bus.in_valid;
  assign d[0] = bus.data_in;
  assign s[0] = bus.shamt;
  assign o[0] = bus.op;

  assign rdy[NUM_STAGES] = bus.out_ready;
  // Ready ripples back from out_ready through the valid bits only; it
  // never depends on in_valid.
  assign bus.in_ready = rdy[0];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
      shift_stage #(
        .DIST (stage_dist(gi))
      ) u_stage (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .in_valid     (v[gi]),
        .in_data      (d[gi]),
        .in_shamt     (s[gi]),
        .in_op        (o[gi]),
        .ready        (rdy[gi]),
        .ready_next   (rdy[gi+1]),
        .out_valid    (v[gi+1]),
        .out_data     (d[gi+1]),
        .out_shamt    (s[gi+1]),
        .out_op       (o[gi+1])
      );
    end
  endgenerate

  assign bus.out_valid = v[NUM_STAGES];
  assign bus.data_out  = d[NUM_STAGES];

  // The last stage's shamt/op are fully consumed and have no reader.
  logic unused_tail;
  assign unused_tail = ^{s[NUM_STAGES], o[NUM_STAGES]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
module tb_pipelined_barrel_shifter;
  import pipelined_barrel_shifter_pkg::*;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clock = 1'b0;
  logic ctrl_reset_n;
  pipelined_barrel_shifter_if bus ();

  pipelined_barrel_shifter dut (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .bus          (bus)
  );

  always #5 clock = ~clock;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   drops = 0;
  int   n_out = 0;
  bit   lat_chk    = 0;
  bit   stream_chk = 0;
  bit   rand_done  = 0;
  exp_t sbq [$];
  exp_t mon_e;

  always @(posedge clock) cyc <= cyc + 1;

  // Reference model: shifts written directly from the operator meaning.
  function automatic logic [31:0] ref_shift(input logic [31:0] d,
                                            input logic [4:0] s,
                                            input logic o);
    logic signed [31:0] sd;
    sd = d;
    if (o == SHIFT_OP_SRA) return 32'(sd >>> s);
    return d << s;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Offer one operation; the expected result is queued once it is accepted.
  task automatic send(input logic [31:0] dv, input logic [4:0] sv, input logic ov,
                      input logic [31:0] expv);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.data_in  = dv;
    bus.shamt    = sv;
    bus.op       = ov;
    @(negedge clock);
    while (!bus.in_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout got=in_ready_low want=accept");
    end else begin
      sbq.push_back('{expv, cyc});
    end
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    bus.data_in  = $urandom;
    bus.shamt    = 5'($urandom);
    bus.op       = 1'($urandom);
  endtask

  task automatic send_rand();
    logic [31:0] dv;
    logic [4:0]  sv;
    logic        ov;
    dv = $urandom;
    sv = 5'($urandom_range(0, 31));
    ov = 1'($urandom_range(0, 1));
    send(dv, sv, ov, ref_shift(dv, sv, ov));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() > 0 && n < 300) begin
      tick(1);
      n++;
    end
    if (sbq.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout got=%0d_left want=0", sbq.size());
    end
    tick(2);
  endtask

  // Monitor: pops the scoreboard whenever a result transfer is about to occur.
  always @(negedge clock) begin
    if (ctrl_reset_n && bus.out_valid && bus.out_ready) begin
      total++;
      n_out++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out got=%h want=no_output", bus.data_out);
      end else begin
        mon_e = sbq.pop_front();
        if (bus.data_out !== mon_e.data) begin
          bad++;
          $display("FAIL data_out got=%h want=%h", bus.data_out, mon_e.data);
        end else begin
          $display("out #%0d data=%h", n_out, bus.data_out);
        end
        if (lat_chk) begin
          total++;
          if (cyc - mon_e.cyc != 5) begin
            bad++;
            $display("FAIL latency got=%0d want=5", cyc - mon_e.cyc);
          end
        end
      end
    end
    if (stream_chk && !bus.in_ready) drops++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.shamt     = '0;
    bus.op        = SHIFT_OP_SLL;
    bus.out_ready = 1'b1;
    ctrl_reset_n  = 1'b0;
    tick(3);
    ctrl_reset_n  = 1'b1;
    @(negedge clock);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data_out", bus.data_out, 32'h0000_0000);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    tick(1);

    // Directed corner values with latency checking.
    lat_chk = 1;
    send(32'h0000_FFFF, 5'd16, SHIFT_OP_SLL, 32'hFFFF_0000);
    drain();
    send(32'h8000_0000, 5'd31, SHIFT_OP_SRA, 32'hFFFF_FFFF);
    send(32'h7FFF_FFF0, 5'd4,  SHIFT_OP_SRA, 32'h07FF_FFFF);
    send(32'h1234_5678, 5'd0,  SHIFT_OP_SLL, 32'h1234_5678);
    send(32'hF000_000F, 5'd31, SHIFT_OP_SLL, 32'h8000_0000);
    send(32'h8765_4321, 5'd0,  SHIFT_OP_SRA, 32'h8765_4321);
    drain();

    // Back-to-back stream: 1 << i, one per cycle.
    stream_chk = 1;
    for (int i = 0; i < 32; i++) begin
      send(32'h1, 5'(i), SHIFT_OP_SLL, 32'h1 << i);
    end
    stream_chk = 0;
    drain();
    check("stream_in_ready_drops", 32'(drops), 32'd0);
    lat_chk = 0;

    // Backpressure: stall the output for 8 cycles during a stream.
    fork
      begin
        for (int i = 0; i < 20; i++) send_rand();
      end
      begin
        tick(3);
        bus.out_ready = 1'b0;
        tick(7);
        @(negedge clock);
        check("bp_in_ready_full", 32'(bus.in_ready), 32'd0);
        @(posedge clock);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Full pipe, then simultaneous accept and emit.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_rand();
    @(negedge clock);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    check("full_out_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clock);
    #1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.data_in   = 32'hC000_0001;
    bus.shamt     = 5'd1;
    bus.op        = SHIFT_OP_SRA;
    @(negedge clock);
    check("simul_in_ready", 32'(bus.in_ready), 32'd1);
    sbq.push_back('{32'hE000_0000, cyc});
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clock);
    check("simul_in_ready_after", 32'(bus.in_ready), 32'd1);
    tick(1);
    drain();

    // Reset with three operations in flight: none may ever come out.
    for (int i = 0; i < 3; i++) send_rand();
    ctrl_reset_n = 1'b0;
    tick(1);
    ctrl_reset_n = 1'b1;
    sbq.delete();
    @(negedge clock);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_data_out", bus.data_out, 32'h0000_0000);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    tick(12);

    // Randomized traffic with random backpressure.
    fork
      begin
        for (int i = 0; i < 150; i++) send_rand();
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          tick(1);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
